spi_slave_param: RTL and testbench

Parametrised SPI slave frame engine, successor to the fixed 10-bit slave. It is clocked by the system clock, with one SPI bit per clk cycle. It deserialises a command+payload frame of DATA_W+2 bits from MOSI and tracks read-address/read-data sequencing. It then serialises DATA_W bits of read data onto MISO. Compared with the fixed slave it adds configurable width, frame-abort detection, a proper transmit handshake, and optional parity checking; it sits between the SPI pins and the RAM/register-file wrapper.

---
 rtl/spi_slave_param_if.sv | 28 ++
 rtl/spi_slave_param.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// spi_slave_param_if: pin-side and memory-side signals of the parametrised SPI slave.
// The master modport is the bench/SPI master plus the memory wrapper; the slave modport is the frame engine.
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  localparam int FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               tx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               rx_valid;
  logic [FRAME_W-1:0] rx_data;
  logic               MISO;
  logic               tx_ready;
  logic               frame_err;
  logic               parity_err;

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  rx_valid, rx_data, MISO, tx_ready, frame_err, parity_err
  );

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output rx_valid, rx_data, MISO, tx_ready, frame_err, parity_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave frame engine, one SPI bit per clk cycle.
// Receives a 2-bit command + DATA_W payload frame MSB first, tracks the
// read-address / read-data sequence, and shifts DATA_W bits of read data out on MISO.
// Optional feature: define SPI_PARITY_EN to expect one odd-parity bit after each frame.
module spi_slave_param #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 4)
) (
  input  logic               clk,
  input  logic               rst,
  spi_slave_param_if.slave   bus
);
  localparam int FRAME_W = DATA_W + 2;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_FRAME   = CNT_W'(FRAME_W);
`else
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_W - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0]  tx_reg_q, tx_reg_d;
  logic               add_exist_q, add_exist_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               tx_ready_q, tx_ready_d;
  logic               frame_err_q, frame_err_d;
`ifdef SPI_PARITY_EN
  logic               parity_err_q, parity_err_d;
`endif
  logic               frame_done;

  // Next-state, shift-register and output-pulse logic; SS_n high overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    tx_reg_d    = tx_reg_q;
    add_exist_d = add_exist_q;
    rx_valid_d  = 1'b0;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef SPI_PARITY_EN
    parity_err_d = 1'b0;
`endif
    frame_done  = 1'b0;

    if (bus.SS_n) begin
      // Deselect: abort whatever is going on; only an unfinished receive is an error.
      state_d = IDLE;
      cnt_d   = '0;
      if (state_q inside {CHK_CMD, WRITE, READ_ADD, READ_DATA}) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          // First command bit; it ends up at FRAME_W-1 once the frame has shifted in.
          rx_data_d = {rx_data_q[FRAME_W-2:0], bus.MOSI};
          cnt_d     = CNT_ONE;
          if (!bus.MOSI)        state_d = WRITE;
          else if (add_exist_q) state_d = READ_DATA;
          else                  state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
`ifdef SPI_PARITY_EN
          if (cnt_q == CNT_FRAME) begin
            // Parity edge: frame bits plus parity bit must hold an odd number of ones.
            if (^{rx_data_q, bus.MOSI}) begin
              frame_done = 1'b1;
            end else begin
              parity_err_d = 1'b1;
              state_d      = HOLD;
            end
          end else begin
            rx_data_d = {rx_data_q[FRAME_W-2:0], bus.MOSI};
            cnt_d     = cnt_q + CNT_ONE;
          end
`else
          rx_data_d = {rx_data_q[FRAME_W-2:0], bus.MOSI};
          cnt_d     = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) frame_done = 1'b1;
`endif
        end
        TX_WAIT: begin
          if (bus.tx_valid) begin
            tx_reg_d = bus.tx_data;
            cnt_d    = '0;
            state_d  = TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          miso_d   = tx_reg_q[DATA_W-1];
          tx_reg_d = {tx_reg_q[DATA_W-2:0], 1'b0};
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_TX_LAST) state_d = HOLD;
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase

      // A complete, accepted frame: publish it and advance the read sequence.
      if (frame_done) begin
        rx_valid_d = 1'b1;
        case (state_q)
          READ_ADD: begin
            add_exist_d = 1'b1;
            state_d     = HOLD;
          end
          READ_DATA: begin
            add_exist_d = 1'b0;
            state_d     = TX_WAIT;
          end
          default: state_d = HOLD;
        endcase
      end
    end

    tx_ready_d = (state_d == TX_WAIT);
  end

  // All state and registered outputs; rst clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_data_q    <= '0;
      tx_reg_q     <= '0;
      add_exist_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      tx_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_data_q    <= rx_data_d;
      tx_reg_q     <= tx_reg_d;
      add_exist_q  <= add_exist_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      tx_ready_q   <= tx_ready_d;
      frame_err_q  <= frame_err_d;
`ifdef SPI_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.MISO      = miso_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.frame_err = frame_err_q;
`ifdef SPI_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: randomized frames against a frame-level model of the slave.
// The driver pushes expected rx frames, error pulses and MISO words into queues;
// a monitor pops and compares whenever the DUT presents an output.
module tb_spi_slave_param;
  localparam int DW = 8;
  localparam int FW = DW + 2;
`ifdef SPI_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  spi_slave_param_if #(.DATA_W(DW)) bus();
  spi_slave_param #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct { logic [FW-1:0] data; int cyc; } rx_exp_t;
  typedef struct { logic [DW-1:0] data; int nbits; } tx_exp_t;
  rx_exp_t rx_q[$];
  int      ferr_q[$];
  int      perr_q[$];
  tx_exp_t tx_q[$];

  // Model of the slave's only hidden memory: whether a read address has been received.
  bit model_add_exist = 1'b0;

  int            mon_bits  = 0;
  bit            mon_delay = 1'b0;
  logic [DW-1:0] mon_word  = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples just after each falling edge, when DUT outputs and TB inputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mon_bits  = 0;
        mon_delay = 1'b0;
        continue;
      end
      if (bus.rx_valid) begin
        if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
        else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e.data));
          check("rx_cycle", cyc, e.cyc);
        end
      end
      if (bus.frame_err) begin
        if (ferr_q.size() == 0) check("frame_err_unexpected", 1, 0);
        else check("frame_err_cycle", cyc, ferr_q.pop_front());
      end
      if (bus.parity_err) begin
        if (perr_q.size() == 0) check("parity_err_unexpected", 1, 0);
        else check("parity_err_cycle", cyc, perr_q.pop_front());
      end
      if (mon_bits > 0 && !mon_delay) begin
        check("miso_bit", 32'(bus.MISO), 32'(mon_word[DW-1]));
        mon_word = mon_word << 1;
        mon_bits--;
      end else begin
        mon_delay = 1'b0;
        check("miso_idle", 32'(bus.MISO), 0);
      end
      if (bus.tx_ready && bus.tx_valid) begin
        if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
        else begin
          tx_exp_t t;
          t = tx_q.pop_front();
          mon_word  = t.data;
          mon_bits  = t.nbits;
          mon_delay = 1'b1;
        end
      end
    end
  end

  task automatic reset_checks(string tag);
    check({tag, "_miso"}, 32'(bus.MISO), 0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 0);
  endtask

  // Asynchronous reset between clock edges while the slave is idle/holding.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("rst_hold");
    model_add_exist = 1'b0;
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One SS_n-low transaction. abort_at: bits delivered before SS_n rises (-1 = none).
  // tx_abort: MISO bits before SS_n rises (-1 = full word); do_rst resets there instead.
  task automatic do_frame(input logic [FW-1:0] bits, input int abort_at, input bit par_ok,
                          input logic [DW-1:0] txd, input int tx_abort, input bit do_rst);
    int   nb;
    bit   good;
    bit   will_tx;
    logic p;
    nb   = PAR ? FW + 1 : FW;
    good = !PAR || par_ok;
    p    = par_ok ? ~^bits : ^bits;
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = DW'($urandom);
      if (abort_at >= 0 && i == abort_at) begin
        bus.SS_n = 1'b1;
        ferr_q.push_back(cyc + 1);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        return;
      end
      bus.MOSI = (i < FW) ? bits[FW-1-i] : p;
      if (i == nb - 1) begin
        if (good) rx_q.push_back('{data: bits, cyc: cyc + 1});
        else      perr_q.push_back(cyc + 1);
      end
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    will_tx = good && bits[FW-1] && model_add_exist;
    if (good && bits[FW-1]) model_add_exist = !model_add_exist;
    check("tx_ready", 32'(bus.tx_ready), 32'(will_tx));
    if (will_tx) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = txd;
      tx_q.push_back('{data: txd, nbits: (tx_abort < 0) ? DW : tx_abort});
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = DW'($urandom);
      if (tx_abort >= 0) begin
        repeat (tx_abort) @(negedge clk);
        if (do_rst) begin
          #2 rst = 1'b1;
          #1 reset_checks("rst_tx");
          model_add_exist = 1'b0;
          @(negedge clk);
          rst = 1'b0;
        end
      end else begin
        repeat (DW + 1) @(negedge clk);
      end
    end
    if (!(will_tx && tx_abort >= 0)) begin
      repeat ($urandom_range(0, 2)) begin
        bus.MOSI = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.SS_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rx_valid", 32'(bus.rx_valid), 0);
    check("reset_rx_data", 32'(bus.rx_data), 0);
    check("reset_miso", 32'(bus.MISO), 0);
    check("reset_tx_ready", 32'(bus.tx_ready), 0);
    check("reset_frame_err", 32'(bus.frame_err), 0);
    check("reset_parity_err", 32'(bus.parity_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_frame(10'h0A5, -1, 1'b1, 8'h00, -1, 1'b0);   // write frame
    do_frame(10'h0A5, 5, 1'b1, 8'h00, -1, 1'b0);    // abort after 5 bits
    do_frame(10'h0A5, -1, 1'b1, 8'h00, -1, 1'b0);   // clean frame afterwards
    do_frame(10'h233, -1, 1'b1, 8'h00, -1, 1'b0);   // read address
    do_frame(10'h300, -1, 1'b1, 8'hC3, -1, 1'b0);   // read data, full word
    do_frame(10'h2F0, -1, 1'b1, 8'h00, -1, 1'b0);
    do_frame(10'h355, -1, 1'b1, 8'h96, 3, 1'b0);    // read data aborted after 3 bits
    do_frame(10'h3AA, -1, 1'b1, 8'h00, -1, 1'b0);   // must be a read address again
    do_frame(10'h300, -1, 1'b1, 8'h5A, 3, 1'b1);    // reset mid-shift
    do_frame(10'h2CC, -1, 1'b1, 8'h00, -1, 1'b0);   // read address after reset
    do_frame(10'h3C0, 4, 1'b1, 8'h00, -1, 1'b0);    // aborted read keeps address
    pulse_reset();                                   // reset clears the stored address
    do_frame(10'h311, -1, 1'b1, 8'h00, -1, 1'b0);
    do_frame(10'h0A5, -1, 1'b0, 8'h00, -1, 1'b0);   // bad parity when enabled
    do_frame(10'h0A5, -1, 1'b1, 8'h00, -1, 1'b0);

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      logic [FW-1:0] b;
      int ab;
      int ta;
      b  = FW'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PAR ? FW : FW - 1) : -1;
      ta = ($urandom_range(0, 2) == 0) ? $urandom_range(0, DW - 1) : -1;
      do_frame(b, ab, ($urandom_range(0, 4) != 0), DW'($urandom), ta, 1'b0);
    end

    repeat (5) @(negedge clk);
    #2;
    check("rx_q_drained", rx_q.size(), 0);
    check("ferr_q_drained", ferr_q.size(), 0);
    check("perr_q_drained", perr_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
